// File: rtl/sntrup_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sntrup_pkg
//  Description : Shared SNTRUP757 datapath constants (modulus, coefficient
//                width, polynomial length and address width).
//  Revision    : 1.0 - initial release
// ============================================================================
package sntrup_pkg;

    // Coefficient modulus
    localparam int Q              = 4591;
    // Bits needed to hold one coefficient mod Q
    localparam int COEF_WIDTH     = 13;
    // Address bits covering one polynomial (2**11 >= P)
    localparam int POLY_ADDR_BITS = 11;
    // Polynomial length
    localparam int P              = 757;

endpackage
`default_nettype wire

// File: rtl/dist_ram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dist_ram_bank
//  Description : One coefficient bank: synchronous write, asynchronous read,
//                mapped to distributed (LUT) RAM. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dist_ram_bank
    import sntrup_pkg::*;
#(
    parameter int WIDTH     = COEF_WIDTH,
    parameter int ADDR_BITS = POLY_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    (* ram_style = "distributed" *)
    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_BITS)-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Asynchronous read; the registered output lives in the parent
    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/poly_ram_pp.sv
`default_nettype none
// ============================================================================
//  Module      : poly_ram_pp
//  Description : Ping-pong polynomial coefficient store. Two banks alternate
//                between producer (write) and consumer (read) roles on a
//                swap pulse. Includes a registered read port, a zero-fill
//                clear engine for the write bank, and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_ram_pp
    import sntrup_pkg::*;
#(
    parameter int WIDTH     = COEF_WIDTH,
    parameter int ADDR_BITS = POLY_ADDR_BITS,
    parameter int DEPTH     = P
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    input  logic                 swap,
    input  logic                 clr_start,
    output logic                 busy,
    output logic                 bank_sel,
    output logic                 wr_drop,
    output logic                 addr_err
);

    // Clear-engine states
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    // One extra bit so DEPTH == 2**ADDR_BITS is still representable
    localparam logic [ADDR_BITS:0]   c_DEPTH = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS-1:0] c_LAST  = ADDR_BITS'(DEPTH - 1);

    logic [0:0]           r_state;
    logic [ADDR_BITS-1:0] r_cnt;
    logic                 r_swap_pend;
    logic                 r_bank_sel;
    logic [WIDTH-1:0]     r_rd_data;
    logic                 r_rd_valid;
    logic                 r_wr_drop;
    logic                 r_addr_err;

    logic                 w_clearing;
    logic                 w_clr_done;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic                 w_wr_ok;
    logic                 w_bank_we;
    logic [ADDR_BITS-1:0] w_bank_waddr;
    logic [WIDTH-1:0]     w_bank_wdata;
    logic [1:0]           w_bank_we_vec;
    logic [WIDTH-1:0]     w_bank_rdata [2];
    logic [WIDTH-1:0]     w_rd_word;

    assign w_clearing    = (r_state == c_CLEAR);
    assign w_clr_done    = w_clearing && (r_cnt == c_LAST);
    assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH);

    // The clear engine owns the write port while active; user writes are dropped
    assign w_wr_ok      = wr_en && !w_clearing && w_wr_in_range;
    assign w_bank_we    = w_clearing || w_wr_ok;
    assign w_bank_waddr = w_clearing ? r_cnt : wr_addr;
    assign w_bank_wdata = w_clearing ? '0 : wr_data;

    // Two identical banks; only the one selected by bank_sel is written
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_bank_we_vec[b] = w_bank_we && (r_bank_sel == 1'(b));

        dist_ram_bank #(
            .WIDTH     (WIDTH),
            .ADDR_BITS (ADDR_BITS)
        ) u_bank (
            .clk   (clk),
            .we    (w_bank_we_vec[b]),
            .waddr (w_bank_waddr),
            .wdata (w_bank_wdata),
            .raddr (rd_addr),
            .rdata (w_bank_rdata[b])
        );
    end

    // Reads always come from the bank not being written
    assign w_rd_word = w_bank_rdata[~r_bank_sel];

    // Clear FSM, bank role selection and deferred swap handling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_swap_pend <= 1'b0;
            r_bank_sel  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // Swap lands first, so a same-cycle clear hits the new write bank
                    if (swap) begin
                        r_bank_sel <= ~r_bank_sel;
                    end
                    if (clr_start) begin
                        r_state <= c_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                c_CLEAR: begin
                    if (w_clr_done) begin
                        r_state     <= c_IDLE;
                        r_cnt       <= '0;
                        r_swap_pend <= 1'b0;
                        // Any number of swaps during the clear collapse to one toggle
                        if (r_swap_pend || swap) begin
                            r_bank_sel <= ~r_bank_sel;
                        end
                    end else begin
                        r_cnt <= r_cnt + ADDR_BITS'(1);
                        if (swap) begin
                            r_swap_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Registered read port; out-of-range reads return zero but still validate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_in_range ? w_rd_word : '0;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_drop  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            if (wr_en && w_clearing) begin
                r_wr_drop <= 1'b1;
            end
            if ((wr_en && !w_wr_in_range) || (rd_en && !w_rd_in_range)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = w_clearing;
    assign bank_sel = r_bank_sel;
    assign wr_drop  = r_wr_drop;
    assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_poly_ram_pp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_ram_pp
//  Description : Self-checking bench for poly_ram_pp. Keeps an array model of
//                both banks plus the current write-bank index and checks the
//                DUT with immediate assertions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_ram_pp;

    localparam int PLEN = 757;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [12:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [10:0] rd_addr = '0;
    logic [12:0] rd_data;
    logic        rd_valid;
    logic        swap = 1'b0;
    logic        clr_start = 1'b0;
    logic        busy;
    logic        bank_sel;
    logic        wr_drop;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents of both banks and which one is writable
    int mdl [2][PLEN];
    int msel = 0;

    poly_ram_pp dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .swap      (swap),
        .clr_start (clr_start),
        .busy      (busy),
        .bank_sel  (bank_sel),
        .wr_drop   (wr_drop),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_bank(input int b);
        for (int i = 0; i < PLEN; i++) mdl[b][i] = 0;
    endtask

    // Idle-state write; the model only takes in-range addresses
    task automatic do_write(input int a, input int d);
        wr_en = 1'b1; wr_addr = a[10:0]; wr_data = d[12:0];
        tick();
        wr_en = 1'b0;
        if (a < PLEN) mdl[msel][a] = d;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
        msel ^= 1;
    endtask

    task automatic rd_check(input int a, input string tag);
        int e;
        rd_en = 1'b1; rd_addr = a[10:0];
        tick();
        rd_en = 1'b0;
        e = (a < PLEN) ? mdl[msel ^ 1][a] : 0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(rd_data), 32'(e));
    endtask

    initial begin
        int n;
        int a;
        int cb;
        int addrs [40];

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_bank_sel", 32'(bank_sel), 0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data",  32'(rd_data),  0);
        chk("rst_wr_drop",  32'(wr_drop),  0);
        chk("rst_addr_err", 32'(addr_err), 0);
        rst = 1'b0;
        tick();

        // ---------------- fill bank 0, swap, read back ----------------
        for (int i = 0; i < PLEN; i++) do_write(i, int'($urandom_range(0, 4590)));
        do_swap();
        chk("swap1_bank_sel", 32'(bank_sel), 1);
        for (int i = 0; i < PLEN; i++) rd_check(i, "fill_read");
        tick();
        chk("idle_rd_valid", 32'(rd_valid), 0);
        chk("idle_rd_hold",  32'(rd_data), 32'(mdl[0][PLEN-1]));

        // ---------------- clear bank 1 while reading bank 0 ----------------
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        cb = msel;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            a = int'($urandom_range(0, PLEN - 1));
            rd_en = 1'b1; rd_addr = a[10:0];
            tick();
            n++;
            chk("clr_read", 32'(rd_data), 32'(mdl[msel ^ 1][a]));
        end
        rd_en = 1'b0;
        zero_bank(cb);
        chk("clr1_busy_len", 32'(n), PLEN);
        chk("clr1_bank_sel", 32'(bank_sel), 1);
        chk("clr1_wr_drop",  32'(wr_drop), 0);
        do_swap();
        chk("swap2_bank_sel", 32'(bank_sel), 0);
        for (int i = 0; i < PLEN; i++) rd_check(i, "cleared_read");

        // ---------------- deferred swap, dropped write during clear ----------------
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        cb = msel;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            swap    = (n == 100 || n == 200);
            wr_en   = (n == 300);
            wr_addr = 11'd5;
            wr_data = 13'h123;
            tick();
            n++;
            if (busy === 1'b1) chk("pend_bank_sel_held", 32'(bank_sel), 0);
        end
        swap = 1'b0; wr_en = 1'b0;
        zero_bank(cb);
        msel ^= 1;
        chk("clr2_busy_len",  32'(n), PLEN);
        chk("pend_toggle",    32'(bank_sel), 1);
        chk("drop_wr_drop",   32'(wr_drop), 1);
        tick();
        chk("pend_single",    32'(bank_sel), 1);
        rd_check(5, "drop_addr5");
        rd_check(0, "clr2_addr0");
        rd_check(PLEN - 1, "clr2_last");

        // ---------------- range errors, same-cycle swap+write ----------------
        for (int i = 0; i < 40; i++) begin
            addrs[i] = int'($urandom_range(0, PLEN - 1));
            do_write(addrs[i], int'($urandom_range(1, 4590)));
        end
        chk("pre_addr_err", 32'(addr_err), 0);
        do_write(800, 13'h0555);
        chk("wr800_addr_err", 32'(addr_err), 1);
        wr_en = 1'b1; wr_addr = 11'd3; wr_data = 13'h1ABC; swap = 1'b1;
        tick();
        wr_en = 1'b0; swap = 1'b0;
        mdl[msel][3] = 32'h1ABC;
        msel ^= 1;
        chk("swapwr_bank_sel", 32'(bank_sel), 0);
        rd_check(3, "swapwr_addr3");
        for (int i = 0; i < 40; i++) rd_check(addrs[i], "rand_read");
        rd_check(3, "pre900");
        rd_check(900, "rd900");

        // ---------------- same-cycle swap + clr_start ----------------
        swap = 1'b1; clr_start = 1'b1;
        tick();
        swap = 1'b0; clr_start = 1'b0;
        msel ^= 1;
        cb = msel;
        chk("swapclr_bank_sel", 32'(bank_sel), 1);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        zero_bank(cb);
        chk("clr3_busy_len", 32'(n), PLEN);
        do_swap();
        rd_check(3, "swapclr_addr3");
        rd_check(addrs[0], "swapclr_rand");

        // ---------------- async reset mid-clear ----------------
        do_swap();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            swap    = (i == 10);
            rd_en   = (i == 49);
            rd_addr = 11'd900;
            tick();
        end
        swap = 1'b0; rd_en = 1'b0;
        chk("pre_rst_busy",     32'(busy),     1);
        chk("pre_rst_bank_sel", 32'(bank_sel), 1);
        chk("pre_rst_rd_valid", 32'(rd_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy",     32'(busy),     0);
        chk("arst_bank_sel", 32'(bank_sel), 0);
        chk("arst_rd_valid", 32'(rd_valid), 0);
        chk("arst_wr_drop",  32'(wr_drop),  0);
        chk("arst_addr_err", 32'(addr_err), 0);
        tick();
        rst = 1'b0;
        msel = 0;
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("post_rst_busy_len", 32'(n), PLEN);
        chk("post_rst_no_pend",  32'(bank_sel), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/poly_ram_pp.md
# poly_ram_pp

Ping-pong polynomial coefficient store for the SNTRUP757 datapath: two identical distributed-RAM banks, one writable by the producer stage and one readable by the consumer stage, exchanged by a single-cycle swap. Adds a registered read port with valid flag, a hardware clear engine that zeroes the write bank one word per cycle, and range checking against the polynomial length. Sits between successive polynomial arithmetic stages so one stage can fill a polynomial while the next consumes the previous one.

## Interface
Parameters:
- WIDTH, 13: coefficient width in bits (holds values mod q = 4591).
- ADDR_BITS, 11: address width; each bank has 2**ADDR_BITS words.
- DEPTH, 757: number of valid coefficients; addresses >= DEPTH are out of range. Must satisfy DEPTH <= 2**ADDR_BITS.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the write bank.
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read strobe for the read bank.
- rd_addr  in  ADDR_BITS  read address.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  high one cycle after an accepted rd_en.
- swap  in  1  single-cycle pulse exchanging the bank roles.
- clr_start  in  1  pulse starting a zero-fill of the current write bank.
- busy  out  1  clear engine active.
- bank_sel  out  1  index of the current write bank; the read bank is !bank_sel.
- wr_drop  out  1  sticky: a write was discarded because busy was high.
- addr_err  out  1  sticky: an out-of-range read or write was presented.

## Operation
- Reset values: bank_sel=0, rd_data=0, rd_valid=0, busy=0, wr_drop=0, addr_err=0, clear counter=0, swap-pending=0. RAM contents are not reset.
- Write: when wr_en && !busy && wr_addr < DEPTH, write bank[wr_addr] <= wr_data at the clock edge. wr_en while busy: discarded, wr_drop set. wr_addr >= DEPTH: discarded, addr_err set.
- Read: when rd_en, rd_data <= read_bank[rd_addr] and rd_valid <= 1 at the next edge; otherwise rd_valid <= 0 and rd_data holds. rd_addr >= DEPTH returns 0 with rd_valid=1 and sets addr_err. Reads are allowed during clear (the clear targets the other bank).
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_start; counter <= 0; busy=1 from the next cycle.
  - CLEAR: writes 0 to write_bank[counter] each cycle, counter increments; after the write at DEPTH-1 -> IDLE, busy=0.
  - clr_start while in CLEAR is ignored.
- Swap: in IDLE, swap toggles bank_sel at the edge. In CLEAR, swap sets swap-pending; the toggle is applied on the edge where CLEAR -> IDLE. Additional swaps while pending are absorbed (a single toggle).
- Sticky flags clear only on rst.

## Timing
- Read latency 1 cycle; throughput one read and one write per cycle.
- Same-cycle swap with wr_en/rd_en: write and read use pre-swap banks; the new roles apply from the following cycle.
- Same-cycle swap with clr_start in IDLE: swap applies first; the clear targets the new write bank (the former read bank).
- Clear duration exactly DEPTH cycles of busy=1 (757 by default).
- Write then read at the same address after a swap: data visible on rd_data 1 cycle after rd_en, with the write at least 1 edge before the swap.
- rst mid-clear: FSM returns to IDLE immediately, pending swap is dropped, and the partially cleared bank contents are undefined.

## Structure
- Shared package sntrup_pkg: Q=4591, COEF_WIDTH=13, POLY_ADDR_BITS=11, P=757; the state enum for this FSM is local.
- Sub-module dist_ram_bank: single-bank distributed RAM (sync write, async read, ram_style distributed), instantiated twice; the output register, muxing, FSM and flags live in poly_ram_pp.

## Test plan
- Reset, then write addr 0..756 with data=addr, swap, then read 0..756 -> rd_data=addr one cycle after each rd_en, rd_valid aligned, and bank_sel=1.
- In IDLE, clr_start -> busy high exactly 757 cycles; after swap, reads of 0..756 return 0.
- Swap pulsed at cycle 100 of a clear -> bank_sel unchanged until the clear finishes, then toggles once; a second swap while pending gives no extra toggle.
- wr_en at addr 5 during busy -> wr_drop=1 and location unchanged; write at addr 800 -> addr_err=1; read of addr 900 -> rd_data=0, rd_valid=1.
- Same-cycle swap + write (addr 3, 0x1ABC) -> the value lands in the pre-swap write bank and is readable immediately via rd_addr 3 (now the read bank).
- rst asserted mid-clear -> busy, bank_sel, flags and rd_valid go to 0 asynchronously; a fresh clr_start works normally.
